issue_ctrl: RTL and testbench
=============================

// Module: issue_ctrl
// PURPOSE
//  Issue/hazard sequencer for the decode stage. Decides each cycle whether decode may latch a new
//  instruction, and inserts a fixed number of bubble cycles after loads (load-use) and after
//  branch/jal/jalr (control). Sits between fetch and decode and drives their stall/bubble inputs.
// PARAMETERS
//  LOAD_STALL  1   bubble cycles inserted after an issued load (mem_to_reg); 0 = none
//  CTRL_STALL  2   bubble cycles inserted after an issued branch/jal/jalr; 0 = none
//  CNT_W       4   width of the bubble counter; LOAD_STALL, CTRL_STALL must be < 2**CNT_W
//  STAT_W      32  width of the statistics counters (ISSUE_STATS_EN only)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  run          in   1       core running; 0 freezes all state
//  ext_stall    in   1       downstream stall; blocks issue, does not advance bubble count
//  dec_valid    in   1       instruction word present at decode input
//  dec_is_load  in   1       decoded insn writes register from memory
//  dec_is_ctrl  in   1       decoded insn is branch, jal or jalr
//  issue        out  1       decode latches the instruction this cycle
//  bubble       out  1       decode must latch a NOP (rd=0, reg_we/mem/branch/jal/jalr = 0)
//  stall_fetch  out  1       fetch must hold pc and instruction word
//  busy         out  1       FSM not in IDLE
//  stat_issued  out  STAT_W  issued instruction count
//  stat_bubbles out  STAT_W  bubble cycle count
// BEHAVIOUR
//  FSM: IDLE, MEM_WAIT, CTRL_WAIT; registered state plus CNT_W-bit down-counter cnt, pend_ctrl flag.
//  issue = run & dec_valid & ~ext_stall & (state==IDLE) -- combinational, zero latency.
//  bubble = run & ~ext_stall & (state!=IDLE); stall_fetch = ~issue; busy = (state!=IDLE).
//  IDLE, issue & dec_is_load & LOAD_STALL>0 -> MEM_WAIT, cnt=LOAD_STALL; pend_ctrl=dec_is_ctrl.
//  IDLE, issue & dec_is_ctrl (no load wait) & CTRL_STALL>0 -> CTRL_WAIT, cnt=CTRL_STALL.
//  Load and ctrl both set: MEM_WAIT first, then CTRL_WAIT (load priority; bubbles add up).
//  Wait states: each cycle with bubble=1, cnt decrements; on the cycle cnt==1 leave the state:
//   MEM_WAIT -> CTRL_WAIT (cnt=CTRL_STALL) if pend_ctrl & CTRL_STALL>0, else IDLE.
//   CTRL_WAIT -> IDLE.
//  Exactly N bubble cycles per hazard; the next insn issues on the cycle right after the last bubble.
//   e.g. load issued cycle 0, LOAD_STALL=1: bubble cycle 1, next issue cycle 2.
//  run=0 or ext_stall=1: no issue, no bubble, state/cnt/pend_ctrl hold; resume where left off.
//  dec_valid=0 in IDLE: no issue, no bubble, stays IDLE.
//  Reset (async, any state): state=IDLE, cnt=0, pend_ctrl=0, stats=0; outputs issue=0, bubble=0,
//   busy=0, stall_fetch=1 (since issue=0). Mid-wait reset discards remaining bubbles.
//  Illegal state encoding -> IDLE next cycle.
// CONFIGURATION
//  ISSUE_STATS_EN defined: stat_issued +1 per issue cycle, stat_bubbles +1 per bubble cycle;
//   both saturate at all-ones (no wrap), cleared only by reset.
//  ISSUE_STATS_EN undefined: stat_issued, stat_bubbles tied to 0; no counter flops.
// TESTING
//  1 ALU stream: dec_valid=1, no load/ctrl, 10 cycles -> issue=1 every cycle, bubble never 1.
//  2 Load then ALU, defaults -> issue c0, bubble c1 only, issue c2; stall_fetch=1 on c1.
//  3 jal, defaults -> issue c0, bubble c1,c2, issue c3; ext_stall=1 on c1 -> bubbles c2,c3, issue c4.
//  4 load+ctrl same insn, defaults -> bubbles c1..c3 (MEM 1 then CTRL 2), issue c4.
//  5 reset_n low mid CTRL_WAIT (after 1 bubble) -> busy=0 immediately; first issue cycle after release.
//  6 ISSUE_STATS_EN, preload counters via force to all-ones - 1, run scenario 2 -> stats stop at all-ones.

Source files
------------

// File: rtl/issue_ctrl_if.sv
// Decode-stage issue/hazard handshake: fetch/decode controls in, issue/bubble/stall decisions out.
interface issue_ctrl_if #(
  parameter int STAT_W = 32
);
  logic              run;
  logic              ext_stall;
  logic              dec_valid;
  logic              dec_is_load;
  logic              dec_is_ctrl;
  logic              issue;
  logic              bubble;
  logic              stall_fetch;
  logic              busy;
  logic [STAT_W-1:0] stat_issued;
  logic [STAT_W-1:0] stat_bubbles;

  modport master (
    output run, ext_stall, dec_valid, dec_is_load, dec_is_ctrl,
    input  issue, bubble, stall_fetch, busy, stat_issued, stat_bubbles
  );

  modport slave (
    input  run, ext_stall, dec_valid, dec_is_load, dec_is_ctrl,
    output issue, bubble, stall_fetch, busy, stat_issued, stat_bubbles
  );
endinterface

// File: rtl/issue_ctrl.sv
// Issue/hazard sequencer: issue and bubble are combinational (zero latency); run=0/ext_stall freeze all state.
// ISSUE_STATS_EN adds saturating issued/bubble counters; without it the stat outputs are tied to 0.
module issue_ctrl #(
  parameter int LOAD_STALL = 1,
  parameter int CTRL_STALL = 2,
  parameter int CNT_W      = 4,
  parameter int STAT_W     = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  issue_ctrl_if.slave  ctl
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEM_WAIT  = 2'd1,
    CTRL_WAIT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_STALL);
  localparam logic [CNT_W-1:0] CTRL_CNT = CNT_W'(CTRL_STALL);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               LOAD_EN  = (LOAD_STALL > 0);
  localparam bit               CTRL_EN  = (CTRL_STALL > 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_ctrl_q, pend_ctrl_d;
  logic             issue;
  logic             bubble;

  // Issue is held low while reset is asserted even if decode presents a valid word.
  assign issue  = reset_n & ctl.run & ctl.dec_valid & ~ctl.ext_stall & (state_q == IDLE);
  assign bubble = ctl.run & ~ctl.ext_stall & (state_q != IDLE);

  assign ctl.issue       = issue;
  assign ctl.bubble      = bubble;
  assign ctl.stall_fetch = ~issue;
  assign ctl.busy        = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_ctrl_d = pend_ctrl_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          if (ctl.dec_is_load && LOAD_EN) begin
            state_d     = MEM_WAIT;
            cnt_d       = LOAD_CNT;
            pend_ctrl_d = ctl.dec_is_ctrl;
          end else if (ctl.dec_is_ctrl && CTRL_EN) begin
            state_d     = CTRL_WAIT;
            cnt_d       = CTRL_CNT;
            pend_ctrl_d = 1'b0;
          end
        end
      end
      MEM_WAIT: begin
        // A zero count here can only come from corruption; treat it like the last bubble.
        if (bubble) begin
          if (cnt_q <= CNT_ONE) begin
            if (pend_ctrl_q && CTRL_EN) begin
              state_d = CTRL_WAIT;
              cnt_d   = CTRL_CNT;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
            pend_ctrl_d = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      CTRL_WAIT: begin
        if (bubble) begin
          if (cnt_q <= CNT_ONE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        pend_ctrl_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_ctrl_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_ctrl_q <= pend_ctrl_d;
    end
  end

`ifdef ISSUE_STATS_EN
  logic [STAT_W-1:0] stat_issued_q, stat_issued_d;
  logic [STAT_W-1:0] stat_bubbles_q, stat_bubbles_d;

  always_comb begin
    stat_issued_d  = stat_issued_q;
    stat_bubbles_d = stat_bubbles_q;
    if (issue && (stat_issued_q != '1)) begin
      stat_issued_d = stat_issued_q + STAT_W'(1);
    end
    if (bubble && (stat_bubbles_q != '1)) begin
      stat_bubbles_d = stat_bubbles_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_issued_q  <= '0;
      stat_bubbles_q <= '0;
    end else begin
      stat_issued_q  <= stat_issued_d;
      stat_bubbles_q <= stat_bubbles_d;
    end
  end

  assign ctl.stat_issued  = stat_issued_q;
  assign ctl.stat_bubbles = stat_bubbles_q;
`else
  assign ctl.stat_issued  = '0;
  assign ctl.stat_bubbles = '0;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: bubble-debt model checked every cycle, plus directed literal expectations.
module tb_issue_ctrl;
  localparam int LS     = 1;
  localparam int CS     = 2;
  localparam int STAT_W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  issue_ctrl_if #(.STAT_W(STAT_W)) bus ();

  issue_ctrl #(
    .LOAD_STALL(LS),
    .CTRL_STALL(CS),
    .CNT_W(4),
    .STAT_W(STAT_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ctl(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: each issued insn owes LS (if load) plus CS (if ctrl) bubbles; nothing issues while debt remains.
  int                owed = 0;
  logic [STAT_W-1:0] m_iss = '0;
  logic [STAT_W-1:0] m_bub = '0;
  logic              pre_req = 1'b0;
  logic              pre_ack = 1'b0;
  logic [STAT_W-1:0] pre_val = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owed  = 0;
      m_iss = '0;
      m_bub = '0;
    end else begin
      if (pre_req != pre_ack) begin
        m_iss   = pre_val;
        m_bub   = pre_val;
        pre_ack = pre_req;
      end
      if (bus.run && !bus.ext_stall) begin
        if (owed > 0) begin
          owed--;
          if (m_bub != '1) m_bub++;
        end else if (bus.dec_valid) begin
          if (m_iss != '1) m_iss++;
          owed = (bus.dec_is_load ? LS : 0) + (bus.dec_is_ctrl ? CS : 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic exp_issue, exp_bubble;
    exp_issue  = reset_n && bus.run && bus.dec_valid && !bus.ext_stall && (owed == 0);
    exp_bubble = bus.run && !bus.ext_stall && (owed > 0);
    check("model.issue", 64'(bus.issue), 64'(exp_issue));
    check("model.bubble", 64'(bus.bubble), 64'(exp_bubble));
    check("model.stall_fetch", 64'(bus.stall_fetch), 64'(!exp_issue));
    check("model.busy", 64'(bus.busy), 64'(owed > 0));
`ifdef ISSUE_STATS_EN
    check("model.stat_issued", 64'(bus.stat_issued), 64'(m_iss));
    check("model.stat_bubbles", 64'(bus.stat_bubbles), 64'(m_bub));
`else
    check("model.stat_issued", 64'(bus.stat_issued), 64'(0));
    check("model.stat_bubbles", 64'(bus.stat_bubbles), 64'(0));
`endif
  end

  // One cycle: drive inputs just after the rising edge, check literal outputs at the falling edge.
  task automatic step(input logic r, input logic v, input logic ld, input logic ct, input logic es,
                      input logic ei, input logic eb, input string nm);
    @(posedge clk);
    #1;
    bus.run = r; bus.dec_valid = v; bus.dec_is_load = ld; bus.dec_is_ctrl = ct; bus.ext_stall = es;
    @(negedge clk);
    check({nm, ".issue"}, 64'(bus.issue), 64'(ei));
    check({nm, ".bubble"}, 64'(bus.bubble), 64'(eb));
  endtask

  initial begin
    bus.run = 1'b0; bus.dec_valid = 1'b0; bus.dec_is_load = 1'b0;
    bus.dec_is_ctrl = 1'b0; bus.ext_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.issue", 64'(bus.issue), 64'(0));
    check("rst.bubble", 64'(bus.bubble), 64'(0));
    check("rst.busy", 64'(bus.busy), 64'(0));
    check("rst.stall_fetch", 64'(bus.stall_fetch), 64'(1));
    check("rst.stat_issued", 64'(bus.stat_issued), 64'(0));
    reset_n = 1'b1;

    // 1: ALU stream
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 1, 0, "alu");
    step(1, 0, 0, 0, 0, 0, 0, "idle_novalid");

    // 2: load then ALU
    step(1, 1, 1, 0, 0, 1, 0, "ld.c0");
    step(1, 1, 0, 0, 0, 0, 1, "ld.c1");
    check("ld.c1.stall_fetch", 64'(bus.stall_fetch), 64'(1));
    step(1, 1, 0, 0, 0, 1, 0, "ld.c2");
    step(1, 0, 0, 0, 0, 0, 0, "ld.idle");

    // 3: jal with ext_stall during the wait
    step(1, 1, 0, 1, 0, 1, 0, "jal.c0");
    step(1, 1, 0, 0, 1, 0, 0, "jal.c1");
    check("jal.c1.busy", 64'(bus.busy), 64'(1));
    step(1, 1, 0, 0, 0, 0, 1, "jal.c2");
    step(1, 1, 0, 0, 0, 0, 1, "jal.c3");
    step(1, 1, 0, 0, 0, 1, 0, "jal.c4");

    // run=0 freezes the wait
    step(1, 1, 0, 1, 0, 1, 0, "frz.c0");
    step(0, 1, 0, 0, 0, 0, 0, "frz.c1");
    step(1, 1, 0, 0, 0, 0, 1, "frz.c2");
    step(1, 1, 0, 0, 0, 0, 1, "frz.c3");
    step(1, 1, 0, 0, 0, 1, 0, "frz.c4");

    // 4: load+ctrl on the same insn
    step(1, 1, 1, 1, 0, 1, 0, "lc.c0");
    step(1, 1, 0, 0, 0, 0, 1, "lc.c1");
    step(1, 1, 0, 0, 0, 0, 1, "lc.c2");
    step(1, 1, 0, 0, 0, 0, 1, "lc.c3");
    step(1, 1, 0, 0, 0, 1, 0, "lc.c4");

    // 5: reset during CTRL_WAIT after one bubble
    step(1, 1, 0, 1, 0, 1, 0, "mr.c0");
    step(1, 1, 0, 0, 0, 0, 1, "mr.c1");
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mr.busy", 64'(bus.busy), 64'(0));
    check("mr.bubble", 64'(bus.bubble), 64'(0));
    check("mr.issue", 64'(bus.issue), 64'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("mr.first_issue", 64'(bus.issue), 64'(1));
    step(1, 1, 0, 0, 0, 1, 0, "mr.next");
    step(1, 0, 0, 0, 0, 0, 0, "mr.idle");

`ifdef ISSUE_STATS_EN
    // 6: saturation from all-ones minus one
    #1;
    pre_val = {{(STAT_W-1){1'b1}}, 1'b0};
    force dut.stat_issued_q  = {{(STAT_W-1){1'b1}}, 1'b0};
    force dut.stat_bubbles_q = {{(STAT_W-1){1'b1}}, 1'b0};
    pre_req = ~pre_req;
    @(posedge clk);
    #1;
    release dut.stat_issued_q;
    release dut.stat_bubbles_q;
    step(1, 1, 1, 0, 0, 1, 0, "sat.c0");
    step(1, 1, 0, 0, 0, 0, 1, "sat.c1");
    check("sat.c1.stat_issued", 64'(bus.stat_issued), 64'(32'hFFFF_FFFF));
    check("sat.c1.stat_bubbles", 64'(bus.stat_bubbles), 64'(32'hFFFF_FFFE));
    step(1, 1, 0, 0, 0, 1, 0, "sat.c2");
    check("sat.c2.stat_bubbles", 64'(bus.stat_bubbles), 64'(32'hFFFF_FFFF));
    step(1, 0, 0, 0, 0, 0, 0, "sat.c3");
    check("sat.c3.stat_issued", 64'(bus.stat_issued), 64'(32'hFFFF_FFFF));
    check("sat.c3.stat_bubbles", 64'(bus.stat_bubbles), 64'(32'hFFFF_FFFF));
`else
    check("nostats.issued", 64'(bus.stat_issued), 64'(0));
    check("nostats.bubbles", 64'(bus.stat_bubbles), 64'(0));
`endif

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
